// File: rtl/minmax_loader_if.sv
// minmax_loader_if: sample-in, finder-write, finder-result and result-out signals of the min/max loader
interface minmax_loader_if #(parameter int DATA_W = 16);
  logic              InValid;
  logic              InReady;
  logic [DATA_W-1:0] InData;
  logic              WriteEn;
  logic [2:0]        WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] Max;
  logic [DATA_W-1:0] Min;
  logic              Valid;
  logic              OutValid;
  logic              OutReady;
  logic [DATA_W-1:0] OutMax;
  logic [DATA_W-1:0] OutMin;
  logic              OutErr;
  logic              Busy;
  modport master (
    input  InValid, InData, Max, Min, Valid, OutReady,
    output InReady, WriteEn, WriteReg, WriteData, OutValid, OutMax, OutMin, OutErr, Busy
  );
  modport slave (
    output InValid, InData, Max, Min, Valid, OutReady,
    input  InReady, WriteEn, WriteReg, WriteData, OutValid, OutMax, OutMin, OutErr, Busy
  );
endinterface

// File: rtl/minmax_loader.sv
// minmax_loader: loads 8 samples into the min/max finder and returns its result; define MINMAX_LOADER_CHECK_EN for the Mismatch cross-check
module minmax_loader #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic reset,
  minmax_loader_if.master bus
`ifdef MINMAX_LOADER_CHECK_EN
  ,
  output logic Mismatch
`endif
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {LOAD, WAIT, DONE} state_t;
  state_t        state;
  logic [2:0]    idx;
  logic [CW-1:0] cnt;
  logic          acc;
  assign acc         = bus.InValid && state == LOAD;
  assign bus.InReady = state == LOAD;
  assign bus.Busy    = state != LOAD || idx != 3'd0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= LOAD;
      idx           <= 3'd0;
      cnt           <= '0;
      bus.WriteEn   <= 1'b0;
      bus.WriteReg  <= 3'd0;
      bus.WriteData <= '0;
      bus.OutValid  <= 1'b0;
      bus.OutMax    <= '0;
      bus.OutMin    <= '0;
      bus.OutErr    <= 1'b0;
    end else begin
      bus.WriteEn <= acc;
      if (acc) begin
        bus.WriteReg  <= idx;
        bus.WriteData <= bus.InData;
        idx           <= idx + 3'd1;
        if (idx == 3'd7) begin
          state <= WAIT;
          cnt   <= '0;
        end
      end
      // cnt == 0 marks the first WAIT cycle, when the finder has not yet seen the last write
      if (state == WAIT) begin
        cnt <= cnt + 1'b1;
        if (cnt != '0 && bus.Valid) begin
          bus.OutMax   <= bus.Max;
          bus.OutMin   <= bus.Min;
          bus.OutErr   <= 1'b0;
          bus.OutValid <= 1'b1;
          state        <= DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          bus.OutErr   <= 1'b1;
          bus.OutValid <= 1'b1;
          state        <= DONE;
        end
      end
      if (state == DONE && bus.OutReady) begin
        bus.OutValid <= 1'b0;
        bus.OutErr   <= 1'b0;
        state        <= LOAD;
      end
    end
  end
`ifdef MINMAX_LOADER_CHECK_EN
  logic [DATA_W-1:0] rmax, rmin;
  always_ff @(posedge clk) begin
    if (reset) begin
      rmax     <= '0;
      rmin     <= '0;
      Mismatch <= 1'b0;
    end else begin
      if (acc) begin
        rmax <= (idx == 3'd0 || bus.InData > rmax) ? bus.InData : rmax;
        rmin <= (idx == 3'd0 || bus.InData < rmin) ? bus.InData : rmin;
      end
      if (state == WAIT)
        Mismatch <= cnt != '0 && bus.Valid && (bus.Max != rmax || bus.Min != rmin);
      if (state == DONE && bus.OutReady)
        Mismatch <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_minmax_loader.sv
// tb_minmax_loader: randomized self-checking bench for minmax_loader with a behavioural finder and write scoreboard
module tb_minmax_loader;
  localparam int TIMEOUT = 16;
  typedef logic [15:0] vec_t [8];
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  minmax_loader_if #(.DATA_W(16)) bus ();
`ifdef MINMAX_LOADER_CHECK_EN
  logic mismatch;
`endif
  minmax_loader #(.DATA_W(16), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef MINMAX_LOADER_CHECK_EN
    ,
    .Mismatch(mismatch)
`endif
  );
  int checks = 0;
  int failures = 0;
  logic exp_ready = 1'b1;
  logic we_exp = 1'b0;
  logic [2:0] acc_n = 3'd0;
  logic [2:0] exp_idx = 3'd0;
  logic [15:0] exp_data [8];
  logic [15:0] regs [8];
  logic fin_go = 1'b0;
  int fin_age = 0;
  int fin_wait = 0;
  logic mute = 1'b0;
  logic bad_max = 1'b0;
  logic [15:0] fmax, fmin;
  logic [15:0] last_mx = 16'h0;
  logic [15:0] last_mn = 16'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural finder: stores writes, reports Valid fin_wait cycles after the write to register 7.
  // It also raises a premature Valid (with stale data) alongside the last write, which the loader must ignore.
  always @(posedge clk) begin
    if (bus.WriteEn) begin
      regs[bus.WriteReg] <= bus.WriteData;
      fin_go  <= bus.WriteReg == 3'd7;
      fin_age <= 0;
    end else if (fin_go) fin_age <= fin_age + 1;
    if (reset) fin_go <= 1'b0;
  end
  always_comb begin
    fmax = regs[0];
    fmin = regs[0];
    for (int i = 1; i < 8; i++) begin
      if (regs[i] > fmax) fmax = regs[i];
      if (regs[i] < fmin) fmin = regs[i];
    end
  end
  assign bus.Valid = !mute && ((fin_go && fin_age >= fin_wait) || (bus.WriteEn && bus.WriteReg == 3'd7));
  assign bus.Max   = bad_max ? 16'h3079 : fmax;
  assign bus.Min   = fmin;

  // Accept model: every sample offered while the loader should be ready is recorded in order.
  always @(posedge clk) begin
    we_exp <= !reset && bus.InValid && exp_ready;
    if (reset) acc_n <= 3'd0;
    else if (bus.InValid && exp_ready) begin
      exp_data[acc_n] <= bus.InData;
      acc_n <= acc_n + 3'd1;
    end
  end

  always @(negedge clk) begin
    if (reset) exp_idx <= 3'd0;
    else begin
      chk("in_ready", 32'(bus.InReady), 32'(exp_ready));
      chk("write_en", 32'(bus.WriteEn), 32'(we_exp));
      if (bus.WriteEn) begin
        chk("write_reg", 32'(bus.WriteReg), 32'(exp_idx));
        chk("write_data", 32'(bus.WriteData), 32'(exp_data[exp_idx]));
        exp_idx <= exp_idx + 3'd1;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input vec_t v, input int n, input int gap_at, input int gap_len, input logic hold);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        bus.InValid = 1'b0;
        repeat (gap_len) step();
      end
      bus.InValid = 1'b1;
      bus.InData  = v[i];
      step();
    end
    bus.InValid = hold;
    if (n == 8) exp_ready = 1'b0;
  endtask

  task automatic check_reset;
    chk("rst_in_ready", 32'(bus.InReady), 32'd1);
    chk("rst_write_en", 32'(bus.WriteEn), 32'd0);
    chk("rst_write_reg", 32'(bus.WriteReg), 32'd0);
    chk("rst_write_data", 32'(bus.WriteData), 32'd0);
    chk("rst_out_valid", 32'(bus.OutValid), 32'd0);
    chk("rst_out_max", 32'(bus.OutMax), 32'd0);
    chk("rst_out_min", 32'(bus.OutMin), 32'd0);
    chk("rst_out_err", 32'(bus.OutErr), 32'd0);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
`ifdef MINMAX_LOADER_CHECK_EN
    chk("rst_mismatch", 32'(mismatch), 32'd0);
`endif
  endtask

  task automatic run(input vec_t v, input int gap_at, input int gap_len, input logic hold, input int stall, input int fw);
    logic [15:0] mx, mn, emx, emn;
    int lat, elat;
    mx = v[0];
    mn = v[0];
    for (int i = 1; i < 8; i++) begin
      if (v[i] > mx) mx = v[i];
      if (v[i] < mn) mn = v[i];
    end
    emx  = mute ? last_mx : (bad_max ? 16'h3079 : mx);
    emn  = mute ? last_mn : mn;
    elat = mute ? TIMEOUT + 1 : 3 + fw;
    fin_wait = fw;
    load(v, 8, gap_at, gap_len, hold);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.OutValid && lat < 60);
    chk("latency", 32'(lat), 32'(elat));
    chk("out_err", 32'(bus.OutErr), 32'(mute));
    chk("out_max", 32'(bus.OutMax), 32'(emx));
    chk("out_min", 32'(bus.OutMin), 32'(emn));
    chk("busy_done", 32'(bus.Busy), 32'd1);
`ifdef MINMAX_LOADER_CHECK_EN
    chk("mismatch", 32'(mismatch), 32'(!mute && bad_max));
`endif
    bus.OutReady = stall == 0;
    for (int s = 1; s <= stall; s++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.OutValid), 32'd1);
      chk("hold_max", 32'(bus.OutMax), 32'(emx));
      chk("hold_min", 32'(bus.OutMin), 32'(emn));
      chk("hold_err", 32'(bus.OutErr), 32'(mute));
      if (s == stall) bus.OutReady = 1'b1;
    end
    step();
    bus.OutReady = 1'b0;
    bus.InValid  = 1'b0;
    exp_ready    = 1'b1;
    @(negedge clk);
    chk("post_valid", 32'(bus.OutValid), 32'd0);
    chk("post_err", 32'(bus.OutErr), 32'd0);
    chk("post_busy", 32'(bus.Busy), 32'd0);
`ifdef MINMAX_LOADER_CHECK_EN
    chk("post_mismatch", 32'(mismatch), 32'd0);
`endif
    last_mx = emx;
    last_mn = emn;
  endtask

  initial begin
    vec_t v1, v;
    v1 = '{16'h0200, 16'h1023, 16'h0306, 16'h000F, 16'h4010, 16'h0C3E, 16'h3079, 16'h061F};
    bus.InValid  = 1'b0;
    bus.InData   = 16'h0;
    bus.OutReady = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    @(negedge clk);
    check_reset();
    run(v1, 8, 0, 1'b0, 0, 0);
    run(v1, 3, 3, 1'b0, 1, 0);
    run(v1, 8, 0, 1'b1, 5, 0);
    mute = 1'b1;
    foreach (v[i]) v[i] = 16'($urandom);
    run(v, 8, 0, 1'b0, 2, 0);
    mute = 1'b0;
    foreach (v[i]) v[i] = 16'($urandom);
    run(v, 8, 0, 1'b0, 0, 1);
    load(v1, 4, 8, 0, 1'b0);
    chk("busy_mid", 32'(bus.Busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check_reset();
    last_mx = 16'h0;
    last_mn = 16'h0;
    run(v1, 8, 0, 1'b0, 0, 0);
`ifdef MINMAX_LOADER_CHECK_EN
    bad_max = 1'b1;
    run(v1, 8, 0, 1'b0, 1, 0);
    bad_max = 1'b0;
    run(v1, 8, 0, 1'b0, 1, 0);
`endif
    repeat (6) begin
      foreach (v[i]) v[i] = 16'($urandom);
      run(v, int'($urandom_range(0, 8)), int'($urandom_range(1, 3)), 1'($urandom),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
